// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state codes,
// opcode constants, instruction classes, ALU function codes and wb_sel codes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6,
    ST_TRAP = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LUI, CL_LOAD, CL_STORE, CL_BR, CL_JAL, CL_SYS, CL_BAD
  } iclass_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic iclass_e decode_class(input logic [6:0] op);
    case (op)
      OP_R:     return CL_R;
      OP_I:     return CL_I;
      OP_LUI:   return CL_LUI;
      OP_LOAD:  return CL_LOAD;
      OP_STORE: return CL_STORE;
      OP_BR:    return CL_BR;
      OP_JAL:   return CL_JAL;
      OP_SYS:   return CL_SYS;
      default:  return CL_BAD;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU function select from the latched instruction class and
// the live funct3/funct7 fields of the IR.
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  iclass_e     iclass,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [3:0]  alu_op
);

  alu_op_e sel;
  logic    alt;
  logic    unused_f7;

  assign alt       = funct7[5];
  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    sel = ALU_ADD;
    case (iclass)
      CL_R, CL_I: begin
        case (funct3)
          // Immediate forms have no SUB; the alt bit only selects SRA there.
          3'b000: sel = (iclass == CL_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001: sel = ALU_SLL;
          3'b010: sel = ALU_SLT;
          3'b011: sel = ALU_SLTU;
          3'b100: sel = ALU_XOR;
          3'b101: sel = alt ? ALU_SRA : ALU_SRL;
          3'b110: sel = ALU_OR;
          3'b111: sel = ALU_AND;
          default: sel = ALU_ADD;
        endcase
      end
      CL_LUI:  sel = ALU_PASSB;
      CL_BR:   sel = ALU_SUB;
      default: sel = ALU_ADD;
    endcase
  end

  assign alu_op = sel;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             trap,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_e            state_q, state_d;
  iclass_e           class_q, class_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [3:0]        alu_op_dec;
  logic              br_ok, br_taken;

  alu_op_decode u_alu_op_decode (
    .iclass (class_q),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (alu_op_dec)
  );

  // Only BEQ/BNE are supported; BNE inverts the zero flag via funct3[0].
  assign br_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign br_taken = br_ok && (alu_zero ^ funct3[0]);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_IF;
      ST_IF:   state_d = ST_ID;
      ST_ID: begin
        class_d = decode_class(opcode);
        case (class_d)
          CL_SYS:  state_d = ST_HALT;
          CL_BAD:  state_d = ST_TRAP;
          default: state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        case (class_q)
          CL_R, CL_I, CL_LUI:  state_d = ST_WB;
          CL_LOAD, CL_STORE:   state_d = ST_MEM;
          CL_BR:               state_d = br_ok ? ST_IF : ST_TRAP;
          CL_JAL:              state_d = ST_IF;
          default:             state_d = ST_TRAP;
        endcase
      end
      ST_MEM:  if (mem_ready) state_d = (class_q == CL_LOAD) ? ST_WB : ST_IF;
      ST_WB:   state_d = ST_IF;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    instret_d = instret_q;
    if (state_d == ST_IF &&
        (state_q == ST_EX || state_q == ST_MEM || state_q == ST_WB))
      instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      class_q   <= CL_R;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    ir_write  = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 4'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    halted    = 1'b0;
    trap      = 1'b0;
    case (state_q)
      ST_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      ST_EX: begin
        alu_op    = alu_op_dec;
        alu_src_b = (class_q == CL_I) || (class_q == CL_LUI) ||
                    (class_q == CL_LOAD) || (class_q == CL_STORE);
        if (class_q == CL_BR) begin
          pc_write = br_taken;
          pc_src   = br_taken;
        end
        if (class_q == CL_JAL) begin
          pc_write  = 1'b1;
          pc_src    = 1'b1;
          reg_write = 1'b1;
          wb_sel    = WB_PC4;
        end
      end
      ST_MEM: begin
        mem_read  = (class_q == CL_LOAD);
        mem_write = (class_q == CL_STORE);
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (class_q == CL_LOAD) ? WB_MEM : WB_ALU;
      end
      ST_HALT: halted = 1'b1;
      ST_TRAP: trap   = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a cycle-level reference model checked
// every cycle, plus literal expectations for latencies and key strobes.
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LUI_OP = 7'b0110111;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] SYS_OP = 7'b1110011;

  logic clk = 1'b0;
  logic rst, start, alu_zero, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic pc_write, pc_src, ir_write, alu_src_b, mem_read, mem_write, reg_write;
  logic halted, trap;
  logic [3:0] alu_op;
  logic [1:0] wb_sel;
  logic [2:0] state_o;
  logic [31:0] instret;

  int total = 0;
  int bad = 0;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .halted(halted), .trap(trap), .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  // Reference model: step number, opcode seen in decode, retired count.
  int          m_st = 0;
  logic [6:0]  m_op = 7'd0;
  logic [31:0] m_instret = 32'd0;
  bit          m_valid = 1'b0;

  function automatic bit known_op(input logic [6:0] op);
    return op == R_OP || op == I_OP || op == LUI_OP || op == LD_OP ||
           op == ST_OP || op == BR_OP || op == JAL_OP;
  endfunction

  always @(posedge clk) begin : model
    int nx;
    if (rst) begin
      m_st = 0;
      m_instret = 32'd0;
      m_valid = 1'b1;
    end else begin
      nx = m_st;
      case (m_st)
        0: if (start) nx = 1;
        1: nx = 2;
        2: begin
          m_op = opcode;
          if (opcode == SYS_OP) nx = 6;
          else if (known_op(opcode)) nx = 3;
          else nx = 7;
        end
        3: begin
          if (m_op == BR_OP) nx = (funct3 <= 3'd1) ? 1 : 7;
          else if (m_op == JAL_OP) nx = 1;
          else if (m_op == LD_OP || m_op == ST_OP) nx = 4;
          else nx = 5;
        end
        4: if (mem_ready) nx = (m_op == LD_OP) ? 5 : 1;
        5: nx = 1;
        default: nx = m_st;
      endcase
      if (nx == 1 && m_st >= 3 && m_st <= 5) m_instret = m_instret + 32'd1;
      m_st = nx;
    end
  end

  function automatic logic [3:0] model_alu(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic alt);
    case (f3)
      3'd0: return (op == R_OP && alt) ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [49:0] exp_vec();
    logic pw, ps, irw, sb, mr, mw, rw, h, t;
    logic [3:0] ao;
    logic [1:0] ws;
    {pw, ps, irw, sb, mr, mw, rw, h, t} = '0;
    ao = 4'd0;
    ws = 2'd0;
    case (m_st)
      1: begin irw = 1'b1; pw = 1'b1; end
      3: begin
        if (m_op == R_OP) ao = model_alu(m_op, funct3, funct7[5]);
        else if (m_op == I_OP) begin ao = model_alu(m_op, funct3, funct7[5]); sb = 1'b1; end
        else if (m_op == LUI_OP) begin ao = 4'd10; sb = 1'b1; end
        else if (m_op == LD_OP || m_op == ST_OP) sb = 1'b1;
        else if (m_op == BR_OP) begin
          ao = 4'd1;
          if (funct3 <= 3'd1 && (alu_zero ^ funct3[0])) begin pw = 1'b1; ps = 1'b1; end
        end else if (m_op == JAL_OP) begin
          pw = 1'b1; ps = 1'b1; rw = 1'b1; ws = 2'd2;
        end
      end
      4: begin mr = (m_op == LD_OP); mw = (m_op == ST_OP); end
      5: begin rw = 1'b1; ws = (m_op == LD_OP) ? 2'd1 : 2'd0; end
      6: h = 1'b1;
      7: t = 1'b1;
      default: ;
    endcase
    return {pw, ps, irw, sb, ao, mr, mw, rw, ws, h, t, 3'(m_st), m_instret};
  endfunction

  always @(negedge clk) begin : compare
    logic [49:0] act, exp;
    if (m_valid) begin
      act = {pc_write, pc_src, ir_write, alu_src_b, alu_op, mem_read, mem_write,
             reg_write, wb_sel, halted, trap, state_o, instret};
      exp = exp_vec();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction starting in IF; returns cycles until the next IF.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int waits,
                           output int lat, output int exop, output int expw,
                           output int wbs, output int mrd);
    int memcnt;
    memcnt = 0; lat = 0; exop = -1; expw = -1; wbs = -1; mrd = 0;
    opcode = op; funct3 = f3; funct7 = f7; alu_zero = z; mem_ready = 1'b1;
    do begin
      tick();
      lat++;
      if (state_o == 3'd4) begin
        memcnt++;
        mem_ready = (memcnt > waits);
      end else mem_ready = 1'b1;
      if (state_o == 3'd3) begin exop = int'(alu_op); expw = int'(pc_write); end
      if (state_o == 3'd5) wbs = int'(wb_sel);
      if (mem_read) mrd++;
    end while (state_o != 3'd1 && lat < 40);
    if (lat >= 40) chk("instr_timeout", int'(state_o), 1);
  endtask

  initial begin
    int lat, exop, expw, wbs, mrd, cnt;
    rst = 1'b1; start = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    alu_zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_state", int'(state_o), 0);
    chk("rst_instret", int'(instret), 0);
    chk("rst_strobes", int'({pc_write, ir_write, mem_read, mem_write, reg_write, halted, trap}), 0);
    rst = 1'b0;
    tick();
    chk("idle_hold", int'(state_o), 0);
    start = 1'b1; opcode = R_OP;
    tick();
    start = 1'b0;
    chk("if_state", int'(state_o), 1);
    chk("if_strobes", int'({ir_write, pc_write}), 3);

    run_instr(R_OP, 3'd0, 7'h00, 1'b0, 0, lat, exop, expw, wbs, mrd);
    chk("add_lat", lat, 4); chk("add_aluop", exop, 0); chk("add_wbsel", wbs, 0);
    chk("add_instret", int'(instret), 1);
    run_instr(R_OP, 3'd0, 7'h20, 1'b0, 0, lat, exop, expw, wbs, mrd);
    chk("sub_lat", lat, 4); chk("sub_aluop", exop, 1);
    run_instr(I_OP, 3'd5, 7'h20, 1'b0, 0, lat, exop, expw, wbs, mrd);
    chk("srai_aluop", exop, 7);
    run_instr(I_OP, 3'd0, 7'h20, 1'b0, 0, lat, exop, expw, wbs, mrd);
    chk("addi_alt_aluop", exop, 0);
    run_instr(LUI_OP, 3'd3, 7'h00, 1'b0, 0, lat, exop, expw, wbs, mrd);
    chk("lui_aluop", exop, 10); chk("lui_lat", lat, 4);
    run_instr(LD_OP, 3'd2, 7'h00, 1'b0, 3, lat, exop, expw, wbs, mrd);
    chk("load_lat", lat, 8); chk("load_mrd_cycles", mrd, 4); chk("load_wbsel", wbs, 1);
    run_instr(ST_OP, 3'd2, 7'h00, 1'b0, 0, lat, exop, expw, wbs, mrd);
    chk("store_lat", lat, 4);
    run_instr(BR_OP, 3'd0, 7'h00, 1'b1, 0, lat, exop, expw, wbs, mrd);
    chk("beq_lat", lat, 3); chk("beq_pcw", expw, 1);
    run_instr(BR_OP, 3'd1, 7'h00, 1'b1, 0, lat, exop, expw, wbs, mrd);
    chk("bne_lat", lat, 3); chk("bne_pcw", expw, 0);
    run_instr(JAL_OP, 3'd0, 7'h00, 1'b0, 0, lat, exop, expw, wbs, mrd);
    chk("jal_lat", lat, 3);
    chk("instret_10", int'(instret), 10);

    opcode = SYS_OP;
    tick(); tick();
    chk("halt_state", int'(state_o), 6);
    start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (halted && state_o == 3'd6) cnt++;
    end
    start = 1'b0;
    chk("halt_hold", cnt, 12);

    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_from_halt_state", int'(state_o), 0);
    chk("rst_from_halt_instret", int'(instret), 0);
    start = 1'b1; opcode = 7'b1111111;
    tick(); start = 1'b0; tick(); tick();
    chk("trap_state", int'(state_o), 7);
    chk("trap_flag", int'(trap), 1);

    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; opcode = BR_OP; funct3 = 3'd2;
    tick(); start = 1'b0; tick(); tick(); tick();
    chk("bad_branch_trap", int'(state_o), 7);

    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; opcode = R_OP; funct3 = 3'd0;
    tick(); start = 1'b0;
    run_instr(R_OP, 3'd0, 7'h00, 1'b0, 0, lat, exop, expw, wbs, mrd);
    opcode = ST_OP; mem_ready = 1'b0;
    for (int i = 0; i < 10 && state_o != 3'd4; i++) tick();
    tick();
    chk("rdm_in_mem", int'(state_o), 4);
    chk("rdm_mem_write", int'(mem_write), 1);
    chk("rdm_instret_pre", int'(instret), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rdm_mem_write_off", int'(mem_write), 0);
    chk("rdm_instret", int'(instret), 0);
    chk("rdm_state", int'(state_o), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
